mem_stage: RTL

Memory stage of the five-stage pipeline, between the EX/MEM latch and the write-back stage. It issues data-cache load/store requests, holds the pipeline until the cache answers, implements LL/SC with a link register, and registers the MEM/WB latch fields that write-back consumes. It turns non-writing slots into register-0 writes, because write-back asserts its register-file write enable on every cycle.

---
 rtl/mem_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-cache requests, LL/SC link register, MEM/WB latch
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_halt,
  input  logic [4:0]  in_wsel,
  input  logic [1:0]  in_wdat_source,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_instr_npc,
  input  logic        in_dREN,
  input  logic        in_dWEN,
  input  logic        in_atomic,
  input  logic [31:0] in_store_data,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        out_halt,
  output logic [4:0]  out_wsel,
  output logic [1:0]  out_wdat_source,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_dmemload,
  output logic [31:0] out_instr_npc
);
  localparam logic [1:0] WRITE_ALU = 2'd0;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        halt_q, halt_d;
  logic [4:0]  wsel_q, wsel_d;
  logic [1:0]  src_q, src_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dml_q, dml_d;
  logic [31:0] npc_q, npc_d;

  logic active, is_sc, sc_ok, sc_fail, capture;

  always_comb begin
    active    = (state_q == RUN) && in_valid && !flush;
    is_sc     = in_atomic && in_dWEN;
    sc_ok     = link_valid_q && (link_addr_q == in_alu_result);
    sc_fail   = is_sc && !sc_ok;
    dmemREN   = active && in_dREN;
    // A failing SC never reaches the cache, so it cannot stall either.
    dmemWEN   = active && in_dWEN && !sc_fail;
    dmemaddr  = active ? in_alu_result : 32'd0;
    dmemstore = active ? in_store_data : 32'd0;
    mem_stall = (dmemREN || dmemWEN) && !dhit;
    capture   = active && !mem_stall;
  end

  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    halt_d       = halt_q;
    wsel_d       = wsel_q;
    src_d        = src_q;
    alu_d        = alu_q;
    dml_d        = dml_q;
    npc_d        = npc_q;
    if (state_q == RUN) begin
      if (capture) begin
        halt_d = in_halt;
        wsel_d = in_wsel;
        src_d  = in_wdat_source;
        alu_d  = in_alu_result;
        npc_d  = in_instr_npc;
        if (in_dREN) dml_d = dmemload;
        if (is_sc) begin
          src_d = WRITE_ALU;
          alu_d = {31'd0, sc_ok};
        end
        if (in_halt) state_d = HALTED;
      end else begin
        halt_d = 1'b0;
        wsel_d = 5'd0;
        src_d  = WRITE_ALU;
        alu_d  = 32'd0;
      end
    end
    if (ccinv && (ccsnoopaddr == link_addr_q)) link_valid_d = 1'b0;
    if (dmemWEN && !in_atomic && dhit && (in_alu_result == link_addr_q)) link_valid_d = 1'b0;
    if (active && is_sc && (sc_fail || dhit)) link_valid_d = 1'b0;
    // An LL completing in the same cycle as a snoop hit re-arms the link.
    if (dmemREN && in_atomic && dhit) begin
      link_valid_d = 1'b1;
      link_addr_d  = in_alu_result;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= RUN;
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'd0;
      halt_q       <= 1'b0;
      wsel_q       <= 5'd0;
      src_q        <= WRITE_ALU;
      alu_q        <= 32'd0;
      dml_q        <= 32'd0;
      npc_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      halt_q       <= halt_d;
      wsel_q       <= wsel_d;
      src_q        <= src_d;
      alu_q        <= alu_d;
      dml_q        <= dml_d;
      npc_q        <= npc_d;
    end
  end

  assign out_halt        = halt_q;
  assign out_wsel        = wsel_q;
  assign out_wdat_source = src_q;
  assign out_alu_result  = alu_q;
  assign out_dmemload    = dml_q;
  assign out_instr_npc   = npc_q;
endmodule
